// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-add-3 ("double dabble"),
// one input bit per clock. It converts an unsigned WIDTH-bit value into
// DIGITS packed BCD nibbles for the downstream per-digit segment decoders.
// Both sides use a valid/ready handshake.
//
// Build option:
//   BIN_TO_BCD_BLANK_EN - adds the 'blank' output, which flags leading-zero
//                         digits for display suppression. When the macro is
//                         undefined the port and its logic are absent.
//
// Parameters:
//   WIDTH   bit width of the unsigned binary input
//   DIGITS  number of BCD output digits (10**DIGITS must exceed 2**WIDTH-1)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   bin holds a value to convert
//   in_ready   block can accept a new value (IDLE only)
//   bin        unsigned operand, sampled on the accept edge only
//   out_valid  bcd holds a completed result
//   out_ready  consumer takes the result
//   bcd        packed BCD result, units digit in bits [3:0]
//   blank      (optional) per-digit leading-zero flags, registered with bcd
//   busy       conversion in progress
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
`ifdef BIN_TO_BCD_BLANK_EN
  output logic [DIGITS-1:0]   blank,
`endif
  output logic                busy
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ScrW = BcdW + WIDTH;
  // The counter only needs to reach WIDTH-1; the completing iteration
  // is recognised while the counter still holds WIDTH-1.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Scratch register: BCD field in the top BcdW bits, binary in the low WIDTH.
  logic [ScrW-1:0] scratch_q, scratch_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic            out_valid_q, out_valid_d;

  logic [ScrW-1:0] adjusted;
  logic [ScrW-1:0] shifted;

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // blank[i] is set when digit i and all digits above it are zero.
  // Digit 0 is never blanked so a zero result still shows one "0".
  function automatic logic [DIGITS-1:0] leading_blank(input logic [BcdW-1:0] value);
    logic [DIGITS-1:0] flags;
    logic              zero_above;
    flags      = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above & (value[4*i +: 4] == 4'd0);
      flags[i]   = zero_above;
    end
    return flags;
  endfunction
`endif

  // Add-3 correction: each BCD nibble >= 5 gets +3 before the shift so it
  // carries correctly into the next digit after doubling. The add is confined
  // to the nibble; it never carries into its neighbour.
  always_comb begin
    adjusted = scratch_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch_q[WIDTH + 4*d +: 4] >= 4'd5) begin
        adjusted[WIDTH + 4*d +: 4] = scratch_q[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    shifted = {adjusted[ScrW-2:0], 1'b0};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    out_valid_d = out_valid_q;
`ifdef BIN_TO_BCD_BLANK_EN
    blank_d     = blank_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          scratch_d = {{BcdW{1'b0}}, bin};
          cnt_d     = '0;
          state_d   = StShift;
        end
      end

      StShift: begin
        scratch_d = shifted;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          bcd_d       = shifted[ScrW-1 -: BcdW];
          out_valid_d = 1'b1;
          state_d     = StDone;
`ifdef BIN_TO_BCD_BLANK_EN
          blank_d     = leading_blank(shifted[ScrW-1 -: BcdW]);
`endif
        end
      end

      StDone: begin
        // in_valid is deliberately ignored here; a new accept can only
        // happen from IDLE, one edge after the output handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StShift);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
`ifdef BIN_TO_BCD_BLANK_EN
  assign blank     = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Self-checking bench for bin_to_bcd_seq at the default 8-bit / 3-digit
// configuration. Expected digits come from plain decimal arithmetic on the
// operand; leading-zero flags (BIN_TO_BCD_BLANK_EN builds) come from
// comparing the operand with powers of ten.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    bin;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0]   blank;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bin_to_bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
`ifdef BIN_TO_BCD_BLANK_EN
    .blank     (blank),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  // Decimal digits by division, one nibble per power of ten.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned         p;
    r = '0;
    p = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i (i>0) is a leading zero exactly when v < 10**i.
  function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
    logic [DIGITS-1:0] b;
    int unsigned       p;
    b = '0;
    p = 10;
    for (int i = 1; i < int'(DIGITS); i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full conversion: accept v, verify latency and result, hold out_ready
  // low for 'stall' cycles of DONE, then complete the handshake.
  task automatic convert(input logic [WIDTH-1:0] v, input int stall);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    bin       = v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_while_busy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    bin      = WIDTH'($urandom);
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(WIDTH));
    check("bcd_result", 32'(bcd), 32'(ref_bcd(int'(v))));
    check("busy_in_done", 32'(busy), 32'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    check("blank_result", 32'(blank), 32'(ref_blank(int'(v))));
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      bin      = WIDTH'($urandom);
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_bcd", 32'(bcd), 32'(ref_bcd(int'(v))));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    check("bcd_held_in_idle", 32'(bcd), 32'(ref_bcd(int'(v))));
  endtask

  initial begin
    logic [WIDTH-1:0] vals [3];
    int               acc [3];
    int               lat;
    int               seen_valid;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin       = '0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bcd", 32'(bcd), 32'h000);
`ifdef BIN_TO_BCD_BLANK_EN
    check("reset_blank", 32'(blank), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Full-scale value with out_ready held high.
    convert(8'd255, 0);

    // Back-to-back accepts with in_valid held high throughout.
    vals[0]   = 8'd0;
    vals[1]   = 8'd99;
    vals[2]   = 8'd100;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      while (!in_ready && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      bin = vals[k];
      @(negedge clk);
      acc[k] = cyc;
      lat    = 0;
      while (!out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("b2b_bcd", 32'(bcd), 32'(ref_bcd(int'(vals[k]))));
    end
    in_valid = 1'b0;
    check("b2b_spacing_0_1", 32'(acc[1] - acc[0]), 32'(WIDTH + 2));
    check("b2b_spacing_1_2", 32'(acc[2] - acc[1]), 32'(WIDTH + 2));
    @(negedge clk);

    // Consumer stalls for 20 cycles; new in_valid must be ignored in DONE.
    convert(8'd173, 20);

    // Reset four cycles into a conversion of 200.
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bin       = 8'd200;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_bcd", 32'(bcd), 32'h000);
    reset      = 1'b0;
    seen_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("midreset_no_out_valid", 32'(seen_valid), 32'd0);
    convert(8'd42, 0);

    // Leading-zero cases (also plain conversions in the default build).
    convert(8'd7, 1);
    convert(8'd0, 0);
    convert(8'd105, 2);
    convert(8'd9, 0);
    convert(8'd10, 0);

    // Randomized operands and consumer stalls.
    for (int n = 0; n < 24; n++) begin
      convert(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
